imem_boot_loader: RTL

- Writes instruction memory before the MIPS core starts fetching from it.
- Accepts a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words.
- Writes each word to sequential imem addresses, then verifies a trailing XOR checksum.
- Holds the core in reset (cpu_rst) until the load succeeds; on any load error the core is never released.

---
 rtl/imem_boot_loader_pkg.sv | 24 ++
 rtl/imem_word_packer.sv | 50 +++++
 rtl/imem_boot_loader.sv | 104 ++++++++++
 3 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and byte-lane convention for the imem boot loader.
// Byte lane 0 occupies bits 7:0 of a word (little-endian), matching the core's memory model.
package imem_boot_loader_pkg;

   typedef enum logic [2:0] {
      StHdr0,
      StHdr1,
      StData,
      StCsum,
      StRun,
      StErr
   } state_e;

   localparam int unsigned HDR_BYTES  = 2;
   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned LANE_W     = 2;

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

   function automatic logic [4:0] lane_lsb(input logic [LANE_W-1:0] lane);
      return {lane, 3'b000};
   endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted stream bytes into little-endian 32-bit words.
// word_valid_o pulses for one cycle after the fourth byte of a word is taken.
module imem_word_packer
   import imem_boot_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        last_lane_o,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   logic [LANE_W-1:0] lane_q;
   logic [31:0]       asm_q, asm_d;
   logic [31:0]       word_q;
   logic              word_valid_q;

   always_comb begin
      asm_d = asm_q;
      asm_d[lane_lsb(lane_q) +: 8] = byte_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lane_q       <= '0;
         asm_q        <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         word_valid_q <= 1'b0;
         if (byte_valid_i) begin
            lane_q <= lane_q + LANE_W'(1);
            if (lane_q == LAST_LANE) begin
               word_q       <= asm_d;
               word_valid_q <= 1'b1;
               asm_q        <= '0;
            end else begin
               asm_q <= asm_d;
            end
         end
      end
   end

   assign last_lane_o  = (lane_q == LAST_LANE);
   assign word_valid_o = word_valid_q;
   assign word_o       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads instruction memory from a byte stream (count, words, XOR checksum) and holds the
// core in reset until the image is verified; any error keeps the core in reset for good.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BOOT_BASE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [16:0]     CAPACITY = 17'(2 ** ADDR_W);
   localparam logic [ADDR_W:0] ONE_W    = (ADDR_W + 1)'(1);

   state_e          state_q, state_d;
   logic            in_ready_q, in_ready_d;
   logic [7:0]      hdr_lo_q;
   logic [ADDR_W:0] cnt_q;
   logic [7:0]      xor_q;
   logic [ADDR_W:0] words_q;

   logic            fire;
   logic [15:0]     hdr_n;
   logic            oversize;
   logic            last_word;
   logic            last_lane;
   logic            word_valid;
   logic [31:0]     word;

   assign fire      = in_valid && in_ready_q;
   assign hdr_n     = {in_data, hdr_lo_q};
   assign oversize  = {1'b0, hdr_n} > CAPACITY;
   // Previous word's write has always landed before the next word's last byte arrives.
   assign last_word = (words_q == (cnt_q - ONE_W));

   imem_word_packer u_packer (
      .clk_i        (clk),
      .rst_i        (rst),
      .byte_valid_i (fire && (state_q == StData)),
      .byte_data_i  (in_data),
      .last_lane_o  (last_lane),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StHdr0: if (fire) state_d = StHdr1;
         StHdr1: begin
            if (fire) begin
               if (oversize)           state_d = StErr;
               else if (hdr_n == '0)   state_d = StCsum;
               else                    state_d = StData;
            end
         end
         StData: if (fire && last_lane && last_word) state_d = StCsum;
         StCsum: if (fire) state_d = (in_data == xor_q) ? StRun : StErr;
         StRun:  state_d = StRun;
         StErr:  state_d = StErr;
         default: state_d = StErr;
      endcase
      in_ready_d = (state_d != StRun) && (state_d != StErr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StHdr0;
         in_ready_q <= 1'b0;
         hdr_lo_q   <= '0;
         cnt_q      <= '0;
         xor_q      <= '0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         if (fire && (state_q == StHdr0)) hdr_lo_q <= in_data;
         if (fire && (state_q == StHdr1)) cnt_q <= hdr_n[ADDR_W:0];
         if (fire && (state_q != StCsum)) xor_q <= xor_q ^ in_data;
         if (imem_we) words_q <= words_q + ONE_W;
      end
   end

   assign in_ready     = in_ready_q;
   assign imem_we      = word_valid && (state_q != StErr);
   assign imem_addr    = BOOT_BASE + words_q[ADDR_W-1:0];
   assign imem_wdata   = word;
   assign cpu_rst      = (state_q != StRun);
   assign load_done    = (state_q == StRun);
   assign load_err     = (state_q == StErr);
   assign words_loaded = words_q;

endmodule
